// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: in-order circular buffer of
// {instr, pc} entries, emptied on an EX-stage redirect.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_if_valid,
    input  logic [31:0]              i_if_instr,
    input  logic [63:0]              i_if_pc,
    output logic                     o_if_ready,
    input  logic                     i_id_stall,
    input  logic                     i_ex_flush,
    output logic                     o_id_valid,
    output logic [31:0]              o_id_instr,
    output logic [63:0]              o_id_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_q [DEPTH];
    logic [63:0]   pc_q    [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // Ready looks only at registered occupancy, so a full queue
    // refuses a push even when decode drains an entry this cycle.
    assign o_if_ready = (count_q < CW'(DEPTH));
    assign o_id_valid = (count_q != '0);
    assign push       = i_if_valid && o_if_ready && !i_ex_flush;
    assign pop        = o_id_valid && !i_id_stall && !i_ex_flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_ex_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_q[wptr_q] <= i_if_instr;
            pc_q[wptr_q]    <= i_if_pc;
        end
    end

    assign o_id_instr = o_id_valid ? instr_q[rptr_q] : NOP_INSTR;
    assign o_id_pc    = o_id_valid ? pc_q[rptr_q]    : 64'h0;
    assign o_count    = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == CW'(DEPTH)));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == '0));

    // Full and empty both alias to equal pointers.
    a_ptr_count: assert property (@(posedge clk) disable iff (rst)
        (count_q[PW-1:0] == PW'(wptr_q - rptr_q)) &&
        ((count_q == '0 || count_q == CW'(DEPTH)) == (wptr_q == rptr_q)));

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue, DEPTH=2 and DEPTH=4 instances
// driven by one shared directed stimulus stream.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] i;
        logic [63:0] p;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [63:0] if_pc = '0;
    logic        id_stall = 1'b0;
    logic        ex_flush = 1'b0;
    logic        started = 1'b0;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int D = (g == 0) ? 2 : 4;
        logic                 ready;
        logic                 valid;
        logic [31:0]          instr;
        logic [63:0]          pc;
        logic [$clog2(D):0]   cnt;
        ent_t                 q[$];
        int                   pre_sz = 0;

        if_id_queue #(.DEPTH(D), .NOP_INSTR(NOP)) dut (
            .clk        (clk),
            .rst        (rst),
            .i_if_valid (if_valid),
            .i_if_instr (if_instr),
            .i_if_pc    (if_pc),
            .o_if_ready (ready),
            .i_id_stall (id_stall),
            .i_ex_flush (ex_flush),
            .o_id_valid (valid),
            .o_id_instr (instr),
            .o_id_pc    (pc),
            .o_count    (cnt)
        );

        // Model update at the edge: accepted pushes enter the scoreboard.
        always @(posedge clk) begin
            if (rst || ex_flush) begin
                q.delete();
            end else if (if_valid && pre_sz < D) begin
                q.push_back('{i: if_instr, p: if_pc});
            end
            pre_sz = q.size();
        end

        // Monitor mid-cycle: state checks, then pop on a decode handshake.
        always @(negedge clk) begin
            if (started) begin
                pre_sz = q.size();
                chk($sformatf("d%0d valid", D), 64'(valid),
                    64'(pre_sz != 0));
                chk($sformatf("d%0d count", D), 64'(cnt), 64'(pre_sz));
                chk($sformatf("d%0d ready", D), 64'(ready),
                    64'(pre_sz < D));
                if (pre_sz == 0) begin
                    chk($sformatf("d%0d nop", D), 64'(instr), 64'(NOP));
                    chk($sformatf("d%0d pc0", D), pc, 64'h0);
                end
                if (valid && !id_stall && !ex_flush && !rst) begin
                    if (q.size() == 0) begin
                        chk($sformatf("d%0d pop_empty", D), 64'(1), 64'(0));
                    end else begin
                        ent_t e;
                        e = q.pop_front();
                        chk($sformatf("d%0d instr", D), 64'(instr), 64'(e.i));
                        chk($sformatf("d%0d pc", D), pc, e.p);
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [63:0] p, input logic st,
                        input logic fl, input logic r);
        if_valid = v;
        if_instr = ins;
        if_pc    = p;
        id_stall = st;
        ex_flush = fl;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic hc(input string nm, input logic v, input logic [31:0] ins,
                      input logic [63:0] p, input int c, input logic rdy);
        chk({nm, " valid"}, 64'(ch[0].valid), 64'(v));
        chk({nm, " instr"}, 64'(ch[0].instr), 64'(ins));
        chk({nm, " pc"}, ch[0].pc, p);
        chk({nm, " count"}, 64'(ch[0].cnt), 64'(c));
        chk({nm, " ready"}, 64'(ch[0].ready), 64'(rdy));
    endtask

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h0060_0113;
    localparam logic [31:0] I2 = 32'h0020_81B3;
    localparam logic [31:0] I3 = 32'h0000_0517;

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        started = 1'b1;
        hc("reset", 0, NOP, 64'h0, 0, 1);

        step(1, I0, 64'h100, 0, 0, 0);
        hc("p1", 1, I0, 64'h100, 1, 1);
        step(1, I1, 64'h104, 0, 0, 0);
        hc("p2", 1, I1, 64'h104, 1, 1);
        step(1, I2, 64'h108, 0, 0, 0);
        hc("p3", 1, I2, 64'h108, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        hc("drain", 0, NOP, 64'h0, 0, 1);

        step(1, I0, 64'h100, 1, 0, 0);
        hc("st1", 1, I0, 64'h100, 1, 1);
        step(1, I1, 64'h104, 1, 0, 0);
        hc("st2", 1, I0, 64'h100, 2, 0);
        step(1, I2, 64'h108, 1, 0, 0);
        hc("st_held", 1, I0, 64'h100, 2, 0);
        step(1, I2, 64'h108, 0, 0, 0);
        hc("full_pp", 1, I1, 64'h104, 1, 1);
        step(1, I2, 64'h108, 1, 0, 0);
        hc("refill", 1, I1, 64'h104, 2, 0);

        step(1, 32'h0000_0033, 64'h10C, 0, 1, 0);
        hc("flush", 0, NOP, 64'h0, 0, 1);
        step(1, I3, 64'h200, 1, 0, 0);
        hc("target", 1, I3, 64'h200, 1, 1);

        step(1, I1, 64'h204, 1, 0, 0);
        hc("full2", 1, I3, 64'h200, 2, 0);
        step(1, I2, 64'h208, 1, 1, 1);
        hc("rst_mid", 0, NOP, 64'h0, 0, 1);
        step(1, I0, 64'h100, 0, 0, 0);
        hc("post_rst", 1, I0, 64'h100, 1, 1);

        for (int i = 0; i < 10; i++) begin
            step(1, 32'h1000_0000 + 32'(i), 64'h300 + 64'(4 * i),
                 1'($urandom_range(0, 1)), 0, 0);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0);

        chk("d2 sb_empty", 64'(ch[0].q.size()), 64'(0));
        chk("d4 sb_empty", 64'(ch[1].q.size()), 64'(0));
        chk("d4 count_end", 64'(ch[1].cnt), 64'(0));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
